dvs_line_dma_sched: RTL and testbench

Line-transfer scheduler sitting between `dvs_cdma_v3` and the AXI CDMA command port. It captures each `write_new_line` pulse as a descriptor: line index, BRAM ping-pong slot and DDR frame buffer. It queues descriptors in a small FIFO and issues one CDMA copy per line (BRAM slot → DDR frame buffer) with a valid/ready handshake. It also tracks frame boundaries, double-buffers DDR frames, and flags overflow and transfer errors.

---
 rtl/dvs_line_dma_sched_pkg.sv | 26 ++
 rtl/dvs_desc_fifo.sv | 63 ++++++
 rtl/dvs_line_dma_sched.sv | 185 ++++++++++++++++++
 tb/tb_dvs_line_dma_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dvs_line_dma_sched_pkg.sv
// Shared definitions for the DVS line-transfer scheduler.
//   - FSM state encodings for the CDMA command sequencer
//   - descriptor packing offsets (buf, slot, line index from LSB upward)
//   - command field widths
package dvs_line_dma_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int CMD_LEN_W = 16;
    localparam int ADDR_W    = 32;

    // Descriptor layout: {line_idx, slot, buf}
    localparam int DESC_BUF_OFF  = 0;
    localparam int DESC_SLOT_OFF = 1;
    localparam int DESC_LINE_OFF = 2;

    // Total descriptor width for a given line-index width.
    function automatic int desc_width(input int line_w);
        return line_w + 2;
    endfunction

endpackage

// File: rtl/dvs_desc_fifo.sv
// Small synchronous descriptor FIFO.
// Ports:
//   pclk, reset_n      clock, asynchronous active-low reset
//   i_push, i_data     write request and data
//   i_pop              read request (head advances)
//   o_data             current head (combinational read of the array)
//   o_full, o_empty    status
//   o_count            number of stored entries
// A push while full is accepted when a pop happens in the same cycle: the
// write lands in the slot the head is vacating.
module dvs_desc_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     pclk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge pclk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dvs_line_dma_sched.sv
// Line-transfer scheduler between dvs_cdma_v3 and an AXI CDMA command port.
// Each write_new_line pulse becomes a descriptor {line, BRAM slot, DDR buf};
// descriptors are queued and issued one at a time as BRAM->DDR copies.
// Ports:
//   pclk, reset_n               clock, asynchronous active-low reset
//   enable                      gate for new descriptors
//   new_frame, write_new_line   pulses from the line capture block
//   frame_base0/1               DDR base of the two frame buffers
//   cmd_valid/ready, cmd_src/dst/len, cmd_done, cmd_err   CDMA command port
//   clr_flags                   clears overflow / err (a coincident set wins)
//   frame_done, ready_buf       last line of a frame landed, and in which buffer
//   overflow, err               sticky drop / transfer-error flags
module dvs_line_dma_sched
    import dvs_line_dma_sched_pkg::*;
#(
    parameter int          LINE_BYTES    = 640,
    parameter int          LINES         = 240,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [31:0] BRAM_AXI_BASE = 32'hC000_0000
) (
    input  logic                 pclk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 new_frame,
    input  logic                 write_new_line,
    input  logic [31:0]          frame_base0,
    input  logic [31:0]          frame_base1,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [31:0]          cmd_src,
    output logic [31:0]          cmd_dst,
    output logic [CMD_LEN_W-1:0] cmd_len,
    input  logic                 cmd_done,
    input  logic                 cmd_err,
    input  logic                 clr_flags,
    output logic                 frame_done,
    output logic                 ready_buf,
    output logic                 overflow,
    output logic                 err
);
    localparam int LW = $clog2(LINES);
    localparam int DW = desc_width(LW);

    // Capture state. The line counter has one spare bit so "past the last
    // line" stays detectable even when LINES is a power of two.
    logic [LW:0]            r_line_cnt;
    logic                   r_wr_slot;
    logic                   r_wr_buf;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [ADDR_W-1:0]      r_cmd_src;
    logic [ADDR_W-1:0]      r_cmd_dst;
    logic [CMD_LEN_W-1:0]   r_cmd_len;
    logic                   r_frame_done;
    logic                   r_ready_buf;
    logic                   r_overflow;
    logic                   r_err;

    logic                   w_push_req;
    logic                   w_line_ok;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_load;
    logic [DW-1:0]          w_push_data;
    logic [DW-1:0]          w_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic [LW-1:0]          w_head_line;
    logic                   w_head_slot;
    logic                   w_head_buf;
    logic [ADDR_W-1:0]      w_src;
    logic [ADDR_W-1:0]      w_dst;

    assign w_push_req  = write_new_line & enable;
    assign w_line_ok   = (r_line_cnt < (LW+1)'(LINES));
    assign w_pop       = (r_state == ST_WAIT) & (cmd_done | cmd_err) & ~w_fifo_empty;
    assign w_drop      = w_push_req & (~w_line_ok | (w_fifo_full & ~w_pop));

    assign w_push_data[DESC_BUF_OFF]       = r_wr_buf;
    assign w_push_data[DESC_SLOT_OFF]      = r_wr_slot;
    assign w_push_data[DESC_LINE_OFF +: LW] = r_line_cnt[LW-1:0];

    assign w_head_buf  = w_head[DESC_BUF_OFF];
    assign w_head_slot = w_head[DESC_SLOT_OFF];
    assign w_head_line = w_head[DESC_LINE_OFF +: LW];

    // Constant multiplies; address arithmetic wraps modulo 2^32.
    assign w_src = BRAM_AXI_BASE + (w_head_slot ? 32'(LINE_BYTES) : 32'd0);
    assign w_dst = (w_head_buf ? frame_base1 : frame_base0)
                 + (32'(w_head_line) * 32'(LINE_BYTES));

    dvs_desc_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk    (pclk),
        .reset_n (reset_n),
        .i_push  (w_push_req & w_line_ok),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Capture: new_frame takes priority over the increment, but a coincident
    // line pulse has already been pushed with the pre-frame values.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_cnt <= '0;
            r_wr_slot  <= 1'b0;
            r_wr_buf   <= 1'b0;
        end else if (new_frame) begin
            r_line_cnt <= '0;
            r_wr_slot  <= 1'b0;
            r_wr_buf   <= ~r_wr_buf;
        end else if (w_push_req && w_line_ok) begin
            r_line_cnt <= r_line_cnt + 1'b1;
            r_wr_slot  <= ~r_wr_slot;
        end
    end

    // FSM: state register
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_fifo_count != '0)     w_state_next = ST_ISSUE;
            ST_ISSUE: if (cmd_ready)              w_state_next = ST_WAIT;
            ST_WAIT:  if (cmd_done || cmd_err)    w_state_next = ST_IDLE;
            default:                              w_state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_valid = (r_state == ST_ISSUE);
        w_load    = (r_state == ST_IDLE) && (w_state_next == ST_ISSUE);
    end

    // Command fields are latched on entry to ISSUE so they stay stable for
    // the whole valid phase.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_src    <= '0;
            r_cmd_dst    <= '0;
            r_cmd_len    <= '0;
            r_frame_done <= 1'b0;
            r_ready_buf  <= 1'b0;
            r_overflow   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_load) begin
                r_cmd_src <= w_src;
                r_cmd_dst <= w_dst;
                r_cmd_len <= CMD_LEN_W'(LINE_BYTES);
            end
            r_frame_done <= (r_state == ST_WAIT) && cmd_done
                            && (w_head_line == LW'(LINES - 1));
            if ((r_state == ST_WAIT) && cmd_done && (w_head_line == LW'(LINES - 1))) begin
                r_ready_buf <= w_head_buf;
            end
            r_overflow <= w_drop | (r_overflow & ~clr_flags);
            r_err      <= ((r_state == ST_WAIT) & cmd_err) | (r_err & ~clr_flags);
        end
    end

    assign cmd_src    = r_cmd_src;
    assign cmd_dst    = r_cmd_dst;
    assign cmd_len    = r_cmd_len;
    assign frame_done = r_frame_done;
    assign ready_buf  = r_ready_buf;
    assign overflow   = r_overflow;
    assign err        = r_err;

endmodule

// File: tb/tb_dvs_line_dma_sched.sv
// Directed bench for dvs_line_dma_sched with hand-computed expected values.
module tb_dvs_line_dma_sched;
    localparam logic [31:0] BASE0 = 32'h1000_0000;
    localparam logic [31:0] BASE1 = 32'h2000_0000;
    localparam logic [31:0] SRC0  = 32'hC000_0000;
    localparam logic [31:0] SRC1  = 32'hC000_0280;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        new_frame = 1'b0;
    logic        write_new_line = 1'b0;
    logic [31:0] frame_base0 = BASE0;
    logic [31:0] frame_base1 = BASE1;
    logic        cmd_ready = 1'b0;
    logic        cmd_done = 1'b0;
    logic        cmd_err = 1'b0;
    logic        clr_flags = 1'b0;
    logic        cmd_valid;
    logic [31:0] cmd_src;
    logic [31:0] cmd_dst;
    logic [15:0] cmd_len;
    logic        frame_done;
    logic        ready_buf;
    logic        overflow;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    dvs_line_dma_sched dut (
        .pclk           (pclk),
        .reset_n        (reset_n),
        .enable         (enable),
        .new_frame      (new_frame),
        .write_new_line (write_new_line),
        .frame_base0    (frame_base0),
        .frame_base1    (frame_base1),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_src        (cmd_src),
        .cmd_dst        (cmd_dst),
        .cmd_len        (cmd_len),
        .cmd_done       (cmd_done),
        .cmd_err        (cmd_err),
        .clr_flags      (clr_flags),
        .frame_done     (frame_done),
        .ready_buf      (ready_buf),
        .overflow       (overflow),
        .err            (err)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_line();
        write_new_line = 1'b1;
        tick();
        write_new_line = 1'b0;
    endtask

    task automatic pulse_frame();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    // Bounded wait for cmd_valid; an expired bound counts as a failed check.
    task automatic wait_valid(input string tag, output bit ok);
        int n = 0;
        while (!cmd_valid && n < 20) begin
            tick();
            n++;
        end
        ok = cmd_valid;
        if (!ok) check({tag, "_timeout"}, 32'(cmd_valid), 32'd1);
    endtask

    // One full command: check fields, handshake, then done/err two cycles later.
    task automatic do_cmd(input string tag, input logic [31:0] esrc, input logic [31:0] edst,
                          input bit use_err, input bit efd);
        bit ok;
        wait_valid(tag, ok);
        if (!ok) return;
        check({tag, "_src"}, cmd_src, esrc);
        check({tag, "_dst"}, cmd_dst, edst);
        check({tag, "_len"}, 32'(cmd_len), 32'd640);
        $display("cmd %s src=%h dst=%h len=%0d %s", tag, cmd_src, cmd_dst, cmd_len,
                 use_err ? "err" : "done");
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check({tag, "_wait_novalid"}, 32'(cmd_valid), 32'd0);
        tick();
        if (use_err) cmd_err = 1'b1;
        else         cmd_done = 1'b1;
        tick();
        cmd_err  = 1'b0;
        cmd_done = 1'b0;
        check({tag, "_frame_done"}, 32'(frame_done), 32'(efd));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;

        // Reset values
        tick();
        tick();
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_src", cmd_src, 32'd0);
        check("rst_dst", cmd_dst, 32'd0);
        check("rst_len", 32'(cmd_len), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_ready_buf", 32'(ready_buf), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();

        // Basic transfer with latency check; new_frame moves capture to buf 1
        pulse_frame();
        write_new_line = 1'b1;
        tick();
        write_new_line = 1'b0;
        check("lat_n", 32'(cmd_valid), 32'd0);
        tick();
        check("lat_n1", 32'(cmd_valid), 32'd1);
        pulse_line();
        do_cmd("basic0", SRC0, BASE1, 1'b0, 1'b0);
        do_cmd("basic1", SRC1, BASE1 + 32'h280, 1'b0, 1'b0);

        // Error path on lines 2 and 3
        pulse_line();
        pulse_line();
        do_cmd("err_l2", SRC0, BASE1 + 32'h500, 1'b1, 1'b0);
        check("err_set", 32'(err), 32'd1);
        do_cmd("err_l3", SRC1, BASE1 + 32'h780, 1'b0, 1'b0);
        check("err_sticky", 32'(err), 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("err_clr", 32'(err), 32'd0);

        // Backpressure: lines 4..9, only four fit; the 6th pulse coincides
        // with clr_flags and the set must win
        cmd_ready = 1'b0;
        for (int p = 1; p <= 6; p++) begin
            if (p == 6) clr_flags = 1'b1;
            write_new_line = 1'b1;
            tick();
            write_new_line = 1'b0;
            clr_flags = 1'b0;
            check($sformatf("ovf_p%0d", p), 32'(overflow), 32'(p >= 5));
            check($sformatf("ovf_valid_p%0d", p), 32'(cmd_valid), 32'(p >= 2));
            if (p >= 2) begin
                check($sformatf("ovf_src_p%0d", p), cmd_src, SRC0);
                check($sformatf("ovf_dst_p%0d", p), cmd_dst, BASE1 + 32'hA00);
            end
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        for (int l = 4; l < 8; l++) begin
            do_cmd($sformatf("drain_l%0d", l), (l % 2) ? SRC1 : SRC0,
                   BASE1 + 32'(l) * 32'd640, 1'b0, 1'b0);
        end

        // Full frame. Two frame starts bring capture back to buf 1 so
        // ready_buf visibly leaves its reset value.
        pulse_frame();
        pulse_frame();
        for (int i = 0; i < 239; i++) begin
            pulse_line();
            do_cmd($sformatf("ff_l%0d", i), (i % 2) ? SRC1 : SRC0,
                   BASE1 + 32'(i) * 32'd640, 1'b0, 1'b0);
        end
        // Last line coincides with new_frame: carries line 239 / buf 1
        new_frame      = 1'b1;
        write_new_line = 1'b1;
        tick();
        new_frame      = 1'b0;
        write_new_line = 1'b0;
        do_cmd("coinc_last", SRC1, BASE1 + 32'h0002_5580, 1'b0, 1'b1);
        check("ff_ready_buf", 32'(ready_buf), 32'd1);
        tick();
        check("fd_one_cycle", 32'(frame_done), 32'd0);
        pulse_line();
        do_cmd("coinc_next", SRC0, BASE0, 1'b0, 1'b0);
        check("ready_buf_hold", 32'(ready_buf), 32'd1);

        // Reset in WAIT (line 1 of buf 0 in flight)
        pulse_line();
        wait_valid("rst_wait", ok);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("rstw_in_wait", 32'(cmd_valid), 32'd0);
        #3 reset_n = 1'b0;
        #1;
        check("rstw_src", cmd_src, 32'd0);
        check("rstw_dst", cmd_dst, 32'd0);
        check("rstw_len", 32'(cmd_len), 32'd0);
        check("rstw_ready_buf", 32'(ready_buf), 32'd0);
        check("rstw_flags", {30'd0, overflow, err}, 32'd0);
        tick();
        #3 reset_n = 1'b1;
        tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        check("stray_fd", 32'(frame_done), 32'd0);
        check("stray_ready_buf", 32'(ready_buf), 32'd0);
        tick();
        check("stray_valid", 32'(cmd_valid), 32'd0);
        pulse_line();
        do_cmd("post_rst", SRC0, BASE0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
